// File: rtl/cap_mem_pkg.sv
// Shared widths, wait-state defaults, FSM encoding and request payload for the
// capability data memory scheduler.
package cap_mem_pkg;

    localparam int unsigned CAP_W         = 129;
    localparam int unsigned ADDR_W        = 32;
    localparam int unsigned WAIT_W        = 4;
    localparam int unsigned WAIT_BASE_DEF = 4;
    localparam int unsigned WAIT_COMP_DEF = 3;
    localparam int unsigned PERF_W        = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2
    } state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [CAP_W-1:0]  wdata;
    } mem_req_t;

endpackage

// File: rtl/cap_mem_sched_if.sv
// Two requester ports plus the memory-side bus of the capability memory scheduler.
interface cap_mem_sched_if;
    import cap_mem_pkg::*;

    logic              req0_valid;
    logic              req0_ready;
    logic              req0_we;
    logic [ADDR_W-1:0] req0_addr;
    logic [CAP_W-1:0]  req0_wdata;
    logic              rsp0_valid;
    logic [CAP_W-1:0]  rsp0_rdata;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_we;
    logic [ADDR_W-1:0] req1_addr;
    logic [CAP_W-1:0]  req1_wdata;
    logic              rsp1_valid;
    logic [CAP_W-1:0]  rsp1_rdata;

    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [CAP_W-1:0]  mem_wdata;
    logic [CAP_W-1:0]  mem_rdata;

    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata,
        input  req1_valid, req1_we, req1_addr, req1_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata,
        output req1_valid, req1_we, req1_addr, req1_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: on conflict the port not granted last wins.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic prio;

    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    // Favour the other port after every accepted grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio <= 1'b0;
        end else if (advance) begin
            prio <= ~grant[1];
        end
    end

endmodule

// File: rtl/cap_mem_sched.sv
// Shares the 129-bit capability data memory between two requesters: one strobe
// cycle then a wait-state countdown. Optional perf counters: CAP_MEM_SCHED_PERF_EN.
module cap_mem_sched
    import cap_mem_pkg::*;
#(
    parameter int unsigned WAIT_BASE = WAIT_BASE_DEF,
    parameter int unsigned WAIT_COMP = WAIT_COMP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_comp,
    cap_mem_sched_if.slave    bus,
    output logic [PERF_W-1:0] busy_cycles,
    output logic [PERF_W-1:0] grant_cnt0,
    output logic [PERF_W-1:0] grant_cnt1
);

    state_e            state;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_load;
    mem_req_t          lat;
    mem_req_t          acc_req;
    logic              port_q;
    logic [1:0]        rsp_v_q;
    logic [CAP_W-1:0]  hold0_q;
    logic [CAP_W-1:0]  hold1_q;
    logic [CAP_W-1:0]  rsp_data;
    logic              mem_read_q;
    logic              mem_write_q;
    logic [1:0]        req_v;
    logic [1:0]        grant;
    logic              idle;
    logic              accept;

    assign req_v  = {bus.req1_valid, bus.req0_valid};
    assign idle   = ~rst & (state == IDLE);
    assign accept = idle & |(req_v & grant);

    assign bus.req0_ready = idle & grant[0];
    assign bus.req1_ready = idle & grant[1];

    rr_arb2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_v),
        .advance (accept),
        .grant   (grant)
    );

    // Payload of the port being granted this cycle.
    always_comb begin
        acc_req.we    = bus.req0_we;
        acc_req.addr  = bus.req0_addr;
        acc_req.wdata = bus.req0_wdata;
        if (grant[1]) begin
            acc_req.we    = bus.req1_we;
            acc_req.addr  = bus.req1_addr;
            acc_req.wdata = bus.req1_wdata;
        end
    end

    assign wait_load = enable_comp ? WAIT_W'(WAIT_COMP) : WAIT_W'(WAIT_BASE);
    assign rsp_data  = lat.we ? '0 : bus.mem_rdata;

    // rsp_valid is raised one edge early so it lands on the wait_cnt==0 cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wait_cnt    <= '0;
            lat         <= '0;
            port_q      <= 1'b0;
            rsp_v_q     <= '0;
            hold0_q     <= '0;
            hold1_q     <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            rsp_v_q     <= '0;
            if (rsp_v_q[0]) hold0_q <= rsp_data;
            if (rsp_v_q[1]) hold1_q <= rsp_data;
            case (state)
                IDLE: begin
                    if (accept) begin
                        lat         <= acc_req;
                        port_q      <= grant[1];
                        wait_cnt    <= wait_load;
                        mem_read_q  <= ~acc_req.we;
                        mem_write_q <= acc_req.we;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    state <= WAIT;
                    if (wait_cnt == '0) rsp_v_q[port_q] <= 1'b1;
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt - WAIT_W'(1);
                        if (wait_cnt == WAIT_W'(1)) rsp_v_q[port_q] <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.mem_addr   = lat.addr;
    assign bus.mem_wdata  = lat.wdata;
    assign bus.rsp0_valid = rsp_v_q[0];
    assign bus.rsp1_valid = rsp_v_q[1];
    assign bus.rsp0_rdata = rsp_v_q[0] ? rsp_data : hold0_q;
    assign bus.rsp1_rdata = rsp_v_q[1] ? rsp_data : hold1_q;

`ifdef CAP_MEM_SCHED_PERF_EN
    logic [PERF_W-1:0] busy_q;
    logic [PERF_W-1:0] gcnt0_q;
    logic [PERF_W-1:0] gcnt1_q;

    // Free-running, wrapping performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q  <= '0;
            gcnt0_q <= '0;
            gcnt1_q <= '0;
        end else begin
            if (state != IDLE)         busy_q  <= busy_q + PERF_W'(1);
            if (accept && !grant[1])   gcnt0_q <= gcnt0_q + PERF_W'(1);
            if (accept && grant[1])    gcnt1_q <= gcnt1_q + PERF_W'(1);
        end
    end

    assign busy_cycles = busy_q;
    assign grant_cnt0  = gcnt0_q;
    assign grant_cnt1  = gcnt1_q;
`else
    assign busy_cycles = '0;
    assign grant_cnt0  = '0;
    assign grant_cnt1  = '0;
`endif

endmodule

// File: tb/tb_cap_mem_sched.sv
// Scoreboard bench for cap_mem_sched: expected responses are queued at accept and
// checked (port, cycle, data) when the DUT responds.
module tb_cap_mem_sched;
    import cap_mem_pkg::*;

    typedef struct {
        int               port;
        logic [CAP_W-1:0] data;
        int               cyc;
    } exp_t;

    localparam logic [CAP_W-1:0]  PRELOAD  = 129'h1_DEAD_BEEF_CAFE_F00D_0123_4567_89AB_BEEF;
    localparam logic [CAP_W-1:0]  WVAL     = 129'h0_1234_5678_9ABC_DEF0_0F1E_2D3C_4B5A_6978;
    localparam logic [ADDR_W-1:0] ADDR_PRE = 32'h10;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              enable_comp = 1'b0;
    logic [PERF_W-1:0] busy_cycles;
    logic [PERF_W-1:0] grant_cnt0;
    logic [PERF_W-1:0] grant_cnt1;

    cap_mem_sched_if bus();

    cap_mem_sched dut (
        .clk         (clk),
        .rst         (rst),
        .enable_comp (enable_comp),
        .bus         (bus),
        .busy_cycles (busy_cycles),
        .grant_cnt0  (grant_cnt0),
        .grant_cnt1  (grant_cnt1)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int fails   = 0;
    int cyc     = 0;
    int acc_cnt0 = 0;
    int acc_cnt1 = 0;
    int busy_exp = 0;

    exp_t exp_q[$];
    int   order_q[$];
    int   acc_q[$];
    logic [CAP_W-1:0] mem_arr [bit [ADDR_W-1:0]];
    logic [CAP_W-1:0] shadow  [bit [ADDR_W-1:0]];

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data appears the cycle after mem_read and is held.
    always @(posedge clk) begin
        if (rst && !mem_arr.exists(ADDR_PRE)) mem_arr[ADDR_PRE] = PRELOAD;
        if (bus.mem_write) mem_arr[bus.mem_addr] = bus.mem_wdata;
        if (bus.mem_read)
            bus.mem_rdata <= mem_arr.exists(bus.mem_addr) ? mem_arr[bus.mem_addr] : '0;
    end

    logic [1:0]       prev_v = '0;
    logic [CAP_W-1:0] prev_d [2];
    logic             prev_strb = 1'b0;
    logic             mon_v;
    logic [CAP_W-1:0] mon_d;
    exp_t             mon_e;

    // Response scoreboard and strobe-width monitor.
    always @(negedge clk) begin
        if (rst) begin
            prev_v    = '0;
            prev_strb = 1'b0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                mon_v = (p == 0) ? bus.rsp0_valid : bus.rsp1_valid;
                mon_d = (p == 0) ? bus.rsp0_rdata : bus.rsp1_rdata;
                if (mon_v) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        fails++;
                        $display("FAIL rsp%0d_unexpected: valid at cycle %0d, required no response", p, cyc);
                    end else begin
                        mon_e = exp_q.pop_front();
                        if (mon_e.port !== p || mon_e.cyc !== cyc || mon_d !== mon_e.data) begin
                            fails++;
                            $display("FAIL rsp_check: got port %0d cycle %0d data %h, required port %0d cycle %0d data %h",
                                     p, cyc, mon_d, mon_e.port, mon_e.cyc, mon_e.data);
                        end
                    end
                end else if (prev_v[p]) begin
                    vectors++;
                    if (mon_d !== prev_d[p]) begin
                        fails++;
                        $display("FAIL rsp%0d_hold: rdata %h, required held %h", p, mon_d, prev_d[p]);
                    end
                end
                prev_v[p] = mon_v;
                prev_d[p] = mon_d;
            end
            if (bus.mem_read || bus.mem_write) begin
                vectors++;
                if (prev_strb || (bus.mem_read && bus.mem_write)) begin
                    fails++;
                    $display("FAIL strobe_width: read %b write %b prev %b, required single one-cycle strobe",
                             bus.mem_read, bus.mem_write, prev_strb);
                end
            end
            prev_strb = bus.mem_read | bus.mem_write;
        end
    end

    task automatic drive(input int p, input logic v, input logic we,
                         input logic [ADDR_W-1:0] a, input logic [CAP_W-1:0] d);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d;
        end
    endtask

    // Hold a request until accepted, then queue its expected response.
    task automatic issue(input int p, input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [CAP_W-1:0] wd, output int acc);
        bit   got;
        int   n;
        exp_t e;
        got = 1'b0;
        acc = -1;
        @(negedge clk);
        drive(p, 1'b1, we, addr, wd);
        for (int i = 0; i < 64 && !got; i++) begin
            #1;
            if ((p == 0) ? bus.req0_ready : bus.req1_ready) begin
                n = enable_comp ? 3 : 4;
                @(posedge clk);
                #1;
                got    = 1'b1;
                acc    = cyc;
                e.port = p;
                e.cyc  = acc + n + 1;
                e.data = we ? '0 : (shadow.exists(addr) ? shadow[addr] : '0);
                if (we) shadow[addr] = wd;
                exp_q.push_back(e);
                order_q.push_back(p);
                acc_q.push_back(acc);
                if (p == 0) acc_cnt0++; else acc_cnt1++;
                busy_exp += n + 2;
            end else begin
                @(negedge clk);
            end
        end
        drive(p, 1'b0, 1'b0, '0, '0);
        vectors++;
        if (!got) begin
            fails++;
            $display("FAIL accept_timeout: port %0d not accepted, required accept within 64 cycles", p);
        end
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain_timeout: %0d responses outstanding, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.delete(); order_q.delete(); acc_q.delete();
        acc_cnt0 = 0; acc_cnt1 = 0; busy_exp = 0;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        #1;
        vectors += 6;
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            fails++; $display("FAIL reset_ready: %b%b, required 00", bus.req1_ready, bus.req0_ready);
        end
        if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
            fails++; $display("FAIL reset_rsp_valid: %b%b, required 00", bus.rsp1_valid, bus.rsp0_valid);
        end
        if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
            fails++; $display("FAIL reset_strobes: %b%b, required 00", bus.mem_read, bus.mem_write);
        end
        if (bus.mem_addr !== '0 || bus.mem_wdata !== '0) begin
            fails++; $display("FAIL reset_mem_bus: addr %h wdata %h, required 0", bus.mem_addr, bus.mem_wdata);
        end
        if (bus.rsp0_rdata !== '0 || bus.rsp1_rdata !== '0) begin
            fails++; $display("FAIL reset_rdata: %h %h, required 0", bus.rsp0_rdata, bus.rsp1_rdata);
        end
        if (busy_cycles !== '0 || grant_cnt0 !== '0 || grant_cnt1 !== '0) begin
            fails++; $display("FAIL reset_perf: %0d %0d %0d, required 0", busy_cycles, grant_cnt0, grant_cnt1);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        int acc;
        enable_comp = 1'b0;
        issue(0, 1'b0, ADDR_PRE, '0, acc);
        @(negedge clk); #1;
        vectors++;
        if (bus.mem_read !== 1'b1 || bus.mem_addr !== ADDR_PRE) begin
            fails++; $display("FAIL read_strobe: read %b addr %h, required 1 %h", bus.mem_read, bus.mem_addr, ADDR_PRE);
        end
        @(negedge clk); #1;
        vectors++;
        if (bus.mem_read !== 1'b0) begin
            fails++; $display("FAIL read_strobe_drop: read %b, required 0", bus.mem_read);
        end
        drain(20);
    endtask

    task automatic test_single_write();
        int acc;
        enable_comp = 1'b1;
        issue(1, 1'b1, 32'h20, WVAL, acc);
        @(negedge clk); #1;
        vectors++;
        if (bus.mem_write !== 1'b1 || bus.mem_read !== 1'b0 || bus.mem_addr !== 32'h20 || bus.mem_wdata !== WVAL) begin
            fails++; $display("FAIL write_strobe: write %b read %b addr %h wdata %h, required 1 0 20 %h",
                              bus.mem_write, bus.mem_read, bus.mem_addr, bus.mem_wdata, WVAL);
        end
        @(negedge clk); #1;
        vectors++;
        if (bus.mem_write !== 1'b0) begin
            fails++; $display("FAIL write_strobe_drop: write %b, required 0", bus.mem_write);
        end
        drain(20);
        enable_comp = 1'b0;
        issue(0, 1'b0, 32'h20, '0, acc);
        drain(20);
    endtask

    task automatic test_round_robin();
        do_reset();
        enable_comp = 1'b0;
        fork
            begin
                int a0;
                for (int i = 0; i < 2; i++) issue(0, 1'b0, ADDR_PRE, '0, a0);
            end
            begin
                int a1;
                for (int i = 0; i < 2; i++) issue(1, 1'b0, 32'h20, '0, a1);
            end
        join
        drain(40);
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= order_q.size() || order_q[i] !== (i % 2)) begin
                fails++; $display("FAIL rr_order[%0d]: got %0d, required %0d", i,
                                  (i < order_q.size()) ? order_q[i] : -1, i % 2);
            end
        end
        for (int i = 1; i < acc_q.size(); i++) begin
            vectors++;
            if (acc_q[i] - acc_q[i-1] !== 7) begin
                fails++; $display("FAIL rr_gap[%0d]: %0d cycles, required 7", i, acc_q[i] - acc_q[i-1]);
            end
        end
    endtask

    task automatic test_comp_toggle();
        int acc;
        enable_comp = 1'b0;
        issue(1, 1'b0, ADDR_PRE, '0, acc);
        repeat (2) @(negedge clk);
        enable_comp = 1'b1;
        drain(20);
        issue(1, 1'b0, ADDR_PRE, '0, acc);
        drain(20);
        enable_comp = 1'b0;
    endtask

    task automatic test_reset_mid_access();
        int acc;
        enable_comp = 1'b0;
        issue(0, 1'b0, ADDR_PRE, '0, acc);
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        drive(0, 1'b1, 1'b0, ADDR_PRE, '0);
        drive(1, 1'b1, 1'b0, 32'h20, '0);
        #1;
        vectors += 4;
        if (bus.mem_read !== 1'b0 || bus.mem_write !== 1'b0) begin
            fails++; $display("FAIL midrst_strobes: %b%b, required 00", bus.mem_read, bus.mem_write);
        end
        if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
            fails++; $display("FAIL midrst_rsp: %b%b, required 00", bus.rsp1_valid, bus.rsp0_valid);
        end
        if (bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0) begin
            fails++; $display("FAIL midrst_ready: %b%b, required 00", bus.req1_ready, bus.req0_ready);
        end
        if (bus.mem_addr !== '0 || bus.rsp0_rdata !== '0) begin
            fails++; $display("FAIL midrst_regs: addr %h rdata %h, required 0", bus.mem_addr, bus.rsp0_rdata);
        end
        exp_q.delete(); order_q.delete(); acc_q.delete();
        acc_cnt0 = 0; acc_cnt1 = 0; busy_exp = 0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        #1;
        rst = 1'b0;
        fork
            begin
                int b0;
                issue(0, 1'b0, ADDR_PRE, '0, b0);
            end
            begin
                int b1;
                issue(1, 1'b0, 32'h20, '0, b1);
            end
        join
        drain(30);
        vectors++;
        if (order_q.size() != 2 || order_q[0] !== 0) begin
            fails++; $display("FAIL midrst_first_grant: got %0d, required 0",
                              (order_q.size() > 0) ? order_q[0] : -1);
        end
    endtask

    task automatic test_perf();
        int acc;
        logic [PERF_W-1:0] e_busy, e_g0, e_g1;
        do_reset();
        enable_comp = 1'b0;
        for (int i = 0; i < 3; i++) issue(0, 1'b0, ADDR_PRE, '0, acc);
        for (int i = 0; i < 2; i++) issue(1, 1'b0, 32'h20, '0, acc);
        drain(30);
        @(negedge clk); #1;
`ifdef CAP_MEM_SCHED_PERF_EN
        e_busy = PERF_W'(busy_exp);
        e_g0   = PERF_W'(acc_cnt0);
        e_g1   = PERF_W'(acc_cnt1);
`else
        e_busy = '0;
        e_g0   = '0;
        e_g1   = '0;
`endif
        vectors += 3;
        if (grant_cnt0 !== e_g0) begin
            fails++; $display("FAIL perf_grant_cnt0: %0d, required %0d", grant_cnt0, e_g0);
        end
        if (grant_cnt1 !== e_g1) begin
            fails++; $display("FAIL perf_grant_cnt1: %0d, required %0d", grant_cnt1, e_g1);
        end
        if (busy_cycles !== e_busy) begin
            fails++; $display("FAIL perf_busy_cycles: %0d, required %0d", busy_cycles, e_busy);
        end
    endtask

    initial begin
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        shadow[ADDR_PRE] = PRELOAD;
        test_reset();
        test_single_read();
        test_single_write();
        test_round_robin();
        test_comp_toggle();
        test_reset_mid_access();
        test_perf();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
